// File: rtl/mem_stage.sv
// mem_stage -- MEM pipeline stage of a MIPS-style five-stage pipeline.
//
// Holds the EX/MEM register, a 4096 x 32-bit data memory, the store
// byte-lane logic, the load extension logic and the MEM/WB register.
// Memory reads are combinational on ALUout_M. Stores commit at the clock
// edge that ends the M cycle. A load in M on the cycle after a store to the
// same word therefore sees the stored data without any hazard logic.
//
// Ports:
//   clk, reset                  rising-edge clock, synchronous active-high reset
//   Instr_E, ALUout_E,          EX-stage values captured into the EX/MEM register
//   RF_RD2_E, PC8_E,
//   WA_E, RegWrite_E
//   ForwardRTM, Write_data_W    W-stage value used as store data when selected
//   Instr_M, ALUout_M,          EX/MEM register contents
//   WA_M, RegWrite_M
//   Instr_W, ALUout_W, DMout_W, MEM/WB register contents (DMout_W is the
//   PC8_W, WA_W, RegWrite_W     extended load data, 0 for non-loads)
//   AdE_W                       registered address-error flag
//
// Build option:
//   MEM_ALIGN_CHECK_EN -- when defined, misaligned word/half accesses are
//   flagged on AdE_W, their memory write is suppressed and DMout_W is forced
//   to 0. When undefined, low address bits are ignored for alignment and
//   AdE_W is tied to 0.
module mem_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Instr_E,
  input  logic [31:0] ALUout_E,
  input  logic [31:0] RF_RD2_E,
  input  logic [31:0] PC8_E,
  input  logic [4:0]  WA_E,
  input  logic        RegWrite_E,
  input  logic        ForwardRTM,
  input  logic [31:0] Write_data_W,
  output logic [31:0] Instr_M,
  output logic [31:0] ALUout_M,
  output logic [4:0]  WA_M,
  output logic        RegWrite_M,
  output logic [31:0] Instr_W,
  output logic [31:0] ALUout_W,
  output logic [31:0] DMout_W,
  output logic [31:0] PC8_W,
  output logic [4:0]  WA_W,
  output logic        RegWrite_W,
  output logic        AdE_W
);

  localparam int DEPTH = 4096;

  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_LH  = 6'b100001;
  localparam logic [5:0] OP_LHU = 6'b100101;
  localparam logic [5:0] OP_LB  = 6'b100000;
  localparam logic [5:0] OP_LBU = 6'b100100;
  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_SH  = 6'b101001;
  localparam logic [5:0] OP_SB  = 6'b101000;

  logic [31:0] rf_rd2_p0;
  logic [31:0] pc8_p0;
  logic [31:0] mem [DEPTH];

  logic [5:0]  op_m;
  logic [1:0]  a_m;
  logic [11:0] idx_m;
  logic [31:0] rd_word_m;
  logic [31:0] st_src_m;
  logic [31:0] st_data_m;
  logic [31:0] st_word_m;
  logic [31:0] ld_data_m;
  logic [3:0]  be_m;
  logic        bad_m;
  logic        st_we_m;

  function automatic logic [3:0] store_be(input logic [5:0] op, input logic [1:0] a);
    case (op)
      OP_SW:   store_be = 4'b1111;
      OP_SH:   store_be = a[1] ? 4'b1100 : 4'b0011;
      OP_SB:   store_be = 4'b0001 << a;
      default: store_be = 4'b0000;
    endcase
  endfunction

  // Replace only the enabled byte lanes of the current word.
  function automatic logic [31:0] store_merge(input logic [3:0]  be,
                                              input logic [31:0] old,
                                              input logic [31:0] d);
    logic [31:0] w;
    w = old;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) w[8*b +: 8] = d[8*b +: 8];
    end
    return w;
  endfunction

  function automatic logic [31:0] load_ext(input logic [5:0]  op,
                                           input logic [1:0]  a,
                                           input logic [31:0] w);
    logic signed [15:0] h;
    logic signed [7:0]  b;
    h = a[1] ? w[31:16] : w[15:0];
    b = w[8*a +: 8];
    case (op)
      OP_LW:   load_ext = w;
      OP_LH:   load_ext = 32'(h);
      OP_LHU:  load_ext = {16'b0, h};
      OP_LB:   load_ext = 32'(b);
      OP_LBU:  load_ext = {24'b0, b};
      default: load_ext = '0;
    endcase
  endfunction

`ifdef MEM_ALIGN_CHECK_EN
  function automatic logic misaligned(input logic [5:0] op, input logic [1:0] a);
    case (op)
      OP_LW, OP_SW:         misaligned = (a != 2'b00);
      OP_LH, OP_LHU, OP_SH: misaligned = a[0];
      default:              misaligned = 1'b0;
    endcase
  endfunction
`endif

  assign op_m      = Instr_M[31:26];
  assign a_m       = ALUout_M[1:0];
  assign idx_m     = ALUout_M[13:2];
  assign rd_word_m = mem[idx_m];
  assign st_src_m  = ForwardRTM ? Write_data_W : rf_rd2_p0;

  // Halfword and byte stores replicate their data across lanes so the
  // byte enables alone pick where it lands.
  always_comb begin
    st_data_m = st_src_m;
    case (op_m)
      OP_SH:   st_data_m = {2{st_src_m[15:0]}};
      OP_SB:   st_data_m = {4{st_src_m[7:0]}};
      default: st_data_m = st_src_m;
    endcase
  end

`ifdef MEM_ALIGN_CHECK_EN
  assign bad_m = misaligned(op_m, a_m);
`else
  assign bad_m = 1'b0;
`endif

  assign be_m      = store_be(op_m, a_m);
  assign st_we_m   = (be_m != 4'b0000) && !bad_m;
  assign st_word_m = store_merge(be_m, rd_word_m, st_data_m);
  assign ld_data_m = bad_m ? 32'h0 : load_ext(op_m, a_m, rd_word_m);

  // Data memory: reset clears every word and discards any store in M.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (st_we_m) begin
      mem[idx_m] <= st_word_m;
    end
  end

  // EX -> MEM
  always_ff @(posedge clk) begin
    if (reset) begin
      Instr_M    <= '0;
      ALUout_M   <= '0;
      rf_rd2_p0  <= '0;
      pc8_p0     <= '0;
      WA_M       <= '0;
      RegWrite_M <= 1'b0;
    end else begin
      Instr_M    <= Instr_E;
      ALUout_M   <= ALUout_E;
      rf_rd2_p0  <= RF_RD2_E;
      pc8_p0     <= PC8_E;
      WA_M       <= WA_E;
      RegWrite_M <= RegWrite_E;
    end
  end

  // MEM -> WB
  always_ff @(posedge clk) begin
    if (reset) begin
      Instr_W    <= '0;
      ALUout_W   <= '0;
      DMout_W    <= '0;
      PC8_W      <= '0;
      WA_W       <= '0;
      RegWrite_W <= 1'b0;
    end else begin
      Instr_W    <= Instr_M;
      ALUout_W   <= ALUout_M;
      DMout_W    <= ld_data_m;
      PC8_W      <= pc8_p0;
      WA_W       <= WA_M;
      RegWrite_W <= RegWrite_M;
    end
  end

`ifdef MEM_ALIGN_CHECK_EN
  always_ff @(posedge clk) begin
    if (reset) AdE_W <= 1'b0;
    else       AdE_W <= bad_m;
  end
`else
  assign AdE_W = 1'b0;
`endif

endmodule
